// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron datapath: Q-format widths, FSM states,
// and the saturation helper used by the requantiser.
package nn_pkg;

  localparam int N_INPUTS  = 28;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;

  typedef enum logic [2:0] {IDLE, FETCH, RUN, BIAS, SCALE, OUT} state_t;

  // Clamp a sign-extended value to the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_to_data(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_requant.sv
// Accumulator-to-output requantiser: drop the fractional bits (floor), saturate to
// DATA_W, optionally clamp negatives to zero. Purely combinational.
module nn_requant #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int RELU      = 1
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] res
);

  logic signed [ACC_W-1:0] sh;

  assign sh = acc >>> FRAC_BITS;

  always_comb begin
    res = DATA_W'(nn_pkg::sat_to_data(64'(sh), DATA_W));
    // Saturated value is in range, so its own sign bit is the sign of the result.
    if (RELU != 0 && res[DATA_W-1]) res = '0;
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// One neuron: streams activations against weights from an external BRAM, accumulates,
// adds bias, requantises and hands the result to the next layer.
module neuron_mac_unit #(
  parameter int N_INPUTS  = nn_pkg::N_INPUTS,
  parameter int ADDR_W    = nn_pkg::ADDR_W,
  parameter int DATA_W    = nn_pkg::DATA_W,
  parameter int FRAC_BITS = nn_pkg::FRAC_BITS,
  parameter int ACC_W     = nn_pkg::ACC_W,
  parameter int RELU      = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_en,
  output logic              w_we,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  import nn_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_INPUTS - 1);

  state_t                     state, state_nx;
  logic [ADDR_W-1:0]          idx;
  logic signed [ACC_W-1:0]    acc;
  logic signed [DATA_W-1:0]   bias_r, rq;
  logic signed [2*DATA_W-1:0] prod;
  logic                       xfer;

  assign prod     = $signed(in_data) * $signed(w_data);
  assign in_ready = (state == RUN);
  assign xfer     = in_ready && in_valid;
  assign busy     = (state != IDLE);
  assign w_we     = 1'b0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   state_nx = RUN;
      RUN:     if (xfer && idx == LAST) state_nx = BIAS;
      BIAS:    state_nx = SCALE;
      SCALE:   state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      bias_r    <= '0;
      w_addr    <= '0;
      w_en      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nx;
      w_en  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bias_r <= bias;
          acc    <= '0;
          idx    <= '0;
          w_addr <= '0;
          w_en   <= 1'b1;
        end
        RUN: if (xfer) begin
          acc <= acc + ACC_W'(prod);
          // Prefetch the next weight so it lands exactly when the next activation can.
          if (idx < LAST) begin
            idx    <= idx + 1'b1;
            w_addr <= idx + 1'b1;
            w_en   <= 1'b1;
          end
        end
        BIAS:  acc <= acc + (ACC_W'(bias_r) <<< FRAC_BITS);
        SCALE: begin
          out_data  <= rq;
          out_valid <= 1'b1;
        end
        OUT:   if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  nn_requant #(
    .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W), .RELU(RELU)
  ) u_rq (
    .acc(acc),
    .res(rq)
  );

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Bench for neuron_mac_unit: ReLU and linear instances share stimulus, each fed by its
// own weight BRAM model; a scoreboard queue is drained by an independent monitor.
module tb_neuron_mac_unit;

  localparam int N = 28;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bias = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready1, w_en1, w_we1, out_valid1, busy1;
  logic [4:0]  w_addr1;
  logic [15:0] w_data1 = '0, out_data1;
  logic        in_ready0, w_en0, w_we0, out_valid0, busy0;
  logic [4:0]  w_addr0;
  logic [15:0] w_data0 = '0, out_data0;

  logic [15:0] wmem [0:31];
  logic [15:0] xin  [0:N-1];

  typedef struct { logic [15:0] d1; logic [15:0] d0; } exp_t;
  exp_t sbq [$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, t0 = 0, hold_n = 0, done_cnt = 0, exp_done = 0;
  bit lat_on = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Weight BRAMs: sampled on the falling edge, output held while enable is low.
  always @(negedge CLK) if (w_en1) w_data1 <= wmem[w_addr1];
  always @(negedge CLK) if (w_en0) w_data0 <= wmem[w_addr0];

  neuron_mac_unit #(.RELU(1)) u_relu (
    .CLK(CLK), .RST(RST), .start(start), .bias(bias), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready1), .w_addr(w_addr1), .w_en(w_en1),
    .w_we(w_we1), .w_data(w_data1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .busy(busy1));

  neuron_mac_unit #(.RELU(0)) u_lin (
    .CLK(CLK), .RST(RST), .start(start), .bias(bias), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready0), .w_addr(w_addr0), .w_en(w_en0),
    .w_we(w_we0), .w_data(w_data0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .busy(busy0));

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  // Reference: exact dot product + bias in Q8.8, floor-divide by 256, clamp, optional ReLU.
  function automatic logic [15:0] model(input logic [15:0] b, input bit relu);
    longint s = 0;
    for (int i = 0; i < N; i++)
      s += longint'($signed(xin[i])) * longint'($signed(wmem[i]));
    s += longint'($signed(b)) * 256;
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return 16'(s);
  endfunction

  task automatic load(input int mode);
    for (int i = 0; i < 32; i++) begin
      if (i >= N) wmem[i] = 16'hDEAD;
      else begin
        case (mode)
          0: begin wmem[i] = 16'h0100; xin[i] = 16'h0100; end
          1: begin wmem[i] = 16'h7FFF; xin[i] = 16'h7FFF; end
          2: begin wmem[i] = 16'hFF00; xin[i] = 16'h0100; end
          3: begin
            wmem[i] = 16'(int'($urandom_range(0, 1023)) - 512);
            xin[i]  = 16'(int'($urandom_range(0, 1023)) - 512);
          end
          default: begin wmem[i] = 16'($urandom); xin[i] = 16'($urandom); end
        endcase
      end
    end
  endtask

  // gap_mode: 0 none, 1 three idle cycles after every 4th transfer, 2 random 0..2 idle.
  task automatic run_eval(input logic [15:0] b, input logic [15:0] e1, input logic [15:0] e0,
                          input int gap_mode, input int hold, input bit lat, input bit poke,
                          input int abort_at);
    exp_t ex;
    int i, gap, g;
    hold_n = hold;
    lat_on = lat;
    if (abort_at == 0) begin
      ex.d1 = e1; ex.d0 = e0;
      sbq.push_back(ex);
      exp_done++;
    end
    @(negedge CLK); start = 1'b1; bias = b; t0 = cyc;
    @(negedge CLK); start = 1'b0; bias = 16'($urandom);
    i = 0; gap = 0; g = 0;
    while (i < N && g < 2000 && !(abort_at != 0 && i == abort_at)) begin
      if (gap > 0) begin
        in_valid = 1'b0; in_data = 16'($urandom); gap--;
      end else begin
        in_valid = 1'b1; in_data = xin[i];
        if (in_ready1) begin
          i++;
          if (gap_mode == 1 && i % 4 == 0) gap = 3;
          else if (gap_mode == 2) gap = $urandom_range(0, 2);
        end
      end
      @(negedge CLK); g++;
    end
    chk("xfer_count", i, (abort_at != 0) ? abort_at : N);
    if (abort_at != 0) begin
      RST = 1'b1;
      @(negedge CLK);
      in_valid = 1'b0;
      chk("rst_in_ready", in_ready1, 0);
      chk("rst_out_valid", out_valid1, 0);
      chk("rst_w_en", w_en1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_busy_lin", busy0, 0);
      RST = 1'b0;
    end else begin
      in_valid = 1'b0;
      if (poke) begin
        g = 0;
        while (!out_valid1 && g < 200) begin @(negedge CLK); g++; end
        start = 1'b1;
        repeat (4) @(negedge CLK);
        start = 1'b0;
      end
      g = 0;
      while (done_cnt != exp_done && g < 300) begin @(negedge CLK); g++; end
      chk("done_count", done_cnt, exp_done);
      @(negedge CLK);
      chk("idle_busy", busy1, 0);
      chk("idle_busy_lin", busy0, 0);
    end
  endtask

  initial begin : monitor
    bit pv, hs, pbusy, cmpl;
    int hc, wcnt;
    logic [15:0] last;
    exp_t ex;
    pv = 0; hs = 0; pbusy = 0; cmpl = 0; hc = 0; wcnt = 0; last = '0;
    forever begin
      @(negedge CLK);
      if (hs) begin
        chk("valid_drop", out_valid1, 0);
        chk("data_keep", out_data1, last);
        hs = 0;
      end
      if (in_ready1 && !busy1) chk("in_ready_idle", in_ready1, 0);
      if (w_we1 !== 1'b0 || w_we0 !== 1'b0) chk("w_we", {w_we1, w_we0}, 0);
      if ({in_ready0, busy0, w_en0, w_addr0, out_valid0} !== {in_ready1, busy1, w_en1, w_addr1, out_valid1})
        chk("lane_match", {in_ready0, busy0, w_en0, w_addr0, out_valid0},
                          {in_ready1, busy1, w_en1, w_addr1, out_valid1});
      if (!RST && w_en1) begin chk("w_addr", w_addr1, wcnt); wcnt++; end
      if (!busy1) begin
        if (pbusy && cmpl) chk("w_en_pulses", wcnt, N);
        wcnt = 0; cmpl = 0;
      end
      pbusy = busy1;
      if (out_valid1) begin
        if (!pv) begin
          hc = hold_n;
          // Inclusive count: cycle start is presented through first cycle out_valid is high.
          if (lat_on) chk("latency", cyc - t0 + 1, 33);
        end
        if (sbq.size() == 0) begin
          chk("unexpected_out", out_valid1, 0);
          out_ready = 1'b1;
        end else if (hc > 0) begin
          out_ready = 1'b0;
          chk("hold_data", out_data1, sbq[0].d1);
          chk("hold_busy", busy1, 1);
          hc--;
        end else begin
          out_ready = 1'b1;
          ex = sbq.pop_front();
          chk("out_relu", out_data1, ex.d1);
          chk("out_lin", out_data0, ex.d0);
          last = out_data1; hs = 1; cmpl = 1;
          done_cnt++;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      pv = out_valid1;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    logic [15:0] rb;
    repeat (3) @(negedge CLK);
    chk("reset_in_ready", in_ready1, 0);
    chk("reset_w_addr", w_addr1, 0);
    chk("reset_w_en", w_en1, 0);
    chk("reset_w_we", w_we1, 0);
    chk("reset_out_data", out_data1, 0);
    chk("reset_out_valid", out_valid1, 0);
    chk("reset_busy", busy1, 0);
    RST = 1'b0;

    load(0); run_eval(16'h0000, 16'h1C00, 16'h1C00, 0, 0, 1, 0, 0);   // unity
    load(0); run_eval(16'h0080, 16'h1C80, 16'h1C80, 1, 0, 0, 0, 0);   // backpressure + bias
    load(1); run_eval(16'h0000, 16'h7FFF, 16'h7FFF, 0, 1, 1, 0, 0);   // saturation
    load(2); run_eval(16'h0000, 16'h0000, 16'hE400, 0, 0, 1, 0, 0);   // negative path
    load(0); run_eval(16'h0000, 16'h1C00, 16'h1C00, 0, 5, 0, 1, 0);   // output hold, start ignored
    run_eval(16'h0000, 16'h1C00, 16'h1C00, 0, 0, 0, 0, 0);

    load(3); rb = 16'($urandom);
    run_eval(rb, 16'h0000, 16'h0000, 0, 0, 0, 0, 10);                 // aborted by reset
    run_eval(rb, model(rb, 1), model(rb, 0), 2, 1, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      rb = 16'($urandom);
      load((k % 2 == 0) ? 3 : 4);
      run_eval(rb, model(rb, 1), model(rb, 0), 2, $urandom_range(0, 3), 0, 0, 0);
    end

    repeat (4) @(negedge CLK);
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
